// File: rtl/tone_scheduler.sv
// Round-robin scheduler sharing one square-wave tone divider among NUM_REQ note sources.
// Each grant plays the winner's half-period for its duration in ms, then inserts a silent gap.
module tone_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int PERIOD_BITS = 16,
  parameter int DUR_BITS    = 12,
  parameter int GAP_MS      = 10
) (
  input  logic                            inputClock,
  input  logic                            reset_n,
  input  logic                            msTick,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PERIOD_BITS-1:0]  halfPeriod,
  input  logic [NUM_REQ*DUR_BITS-1:0]     duration,
  input  logic                            stop,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      activeId,
  output logic                            toneOut,
  output logic                            done
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int GAP_BITS = (GAP_MS < 1) ? 1 : $clog2(GAP_MS + 1);
  localparam logic [GAP_BITS-1:0] GAP_LAST = (GAP_MS > 0) ? GAP_BITS'(GAP_MS - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [NUM_REQ-1:0]      r_ack;
  logic                    r_busy;
  logic [ID_W-1:0]         r_activeId;
  logic                    r_toneOut;
  logic                    r_done;
  logic [ID_W-1:0]         r_ptr;
  logic [PERIOD_BITS-1:0]  r_halfLat;
  logic [DUR_BITS-1:0]     r_durLat;
  logic [PERIOD_BITS-1:0]  r_divCnt;
  logic [DUR_BITS-1:0]     r_msCnt;
  logic [GAP_BITS-1:0]     r_gapCnt;

  logic                    w_anyReq;
  logic [ID_W-1:0]         w_grantIdx;
  logic [ID_W:0]           w_sum;
  logic [ID_W-1:0]         w_cand;
  logic [NUM_REQ-1:0]      w_grantOneHot;
  logic [PERIOD_BITS-1:0]  w_selHalf;
  logic [DUR_BITS-1:0]     w_selDur;
  logic [DUR_BITS-1:0]     w_msNext;
  logic                    w_toneEnd;

  // Search upward from pointer+1 with wrap-around; the sum is one bit wider so it never overflows.
  always_comb begin
    w_anyReq   = 1'b0;
    w_grantIdx = '0;
    w_sum      = '0;
    w_cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!w_anyReq && req[w_cand]) begin
        w_anyReq   = 1'b1;
        w_grantIdx = w_cand;
      end
    end
  end

  always_comb begin
    w_grantOneHot = '0;
    w_selHalf     = '0;
    w_selDur      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantIdx == ID_W'(i)) begin
        w_grantOneHot[i] = 1'b1;
        w_selHalf        = halfPeriod[i*PERIOD_BITS +: PERIOD_BITS];
        w_selDur         = duration[i*DUR_BITS +: DUR_BITS];
      end
    end
  end

  assign w_msNext  = r_msCnt + DUR_BITS'(1);
  assign w_toneEnd = (r_durLat == '0) || (msTick && (w_msNext == r_durLat));

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_activeId <= '0;
      r_toneOut  <= 1'b0;
      r_done     <= 1'b0;
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_halfLat  <= '0;
      r_durLat   <= '0;
      r_divCnt   <= '0;
      r_msCnt    <= '0;
      r_gapCnt   <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state    <= PLAY;
            r_busy     <= 1'b1;
            r_ack      <= w_grantOneHot;
            r_activeId <= w_grantIdx;
            r_ptr      <= w_grantIdx;
            r_halfLat  <= w_selHalf;
            r_durLat   <= w_selDur;
            r_divCnt   <= '0;
            r_msCnt    <= '0;
            r_toneOut  <= 1'b0;
          end
        end
        PLAY: begin
          // stop wins over a completing msTick, and aborts without a done pulse
          if (stop) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_toneOut <= 1'b0;
          end else if (w_toneEnd) begin
            r_state   <= GAP;
            r_done    <= 1'b1;
            r_toneOut <= 1'b0;
            r_gapCnt  <= '0;
          end else begin
            if (msTick) begin
              r_msCnt <= w_msNext;
            end
            if (r_halfLat == '0) begin
              r_toneOut <= 1'b0;
            end else if (r_divCnt == (r_halfLat - PERIOD_BITS'(1))) begin
              r_toneOut <= ~r_toneOut;
              r_divCnt  <= '0;
            end else begin
              r_divCnt <= r_divCnt + PERIOD_BITS'(1);
            end
          end
        end
        GAP: begin
          r_toneOut <= 1'b0;
          if (stop || (GAP_MS == 0) || (msTick && (r_gapCnt == GAP_LAST))) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_gapCnt <= '0;
          end else if (msTick) begin
            r_gapCnt <= r_gapCnt + GAP_BITS'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_toneOut <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign busy     = r_busy;
  assign activeId = r_activeId;
  assign toneOut  = r_toneOut;
  assign done     = r_done;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler; a queue of expected grant ids is checked by a negedge monitor.
module tb_tone_scheduler;

  logic        inputClock = 1'b0;
  logic        reset_n;
  logic        msTick;
  logic [3:0]  req;
  logic [63:0] halfPeriod;
  logic [47:0] duration;
  logic        stop;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  activeId;
  logic        toneOut;
  logic        done;

  logic [15:0] hArr [4];
  logic [11:0] dArr [4];

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount   = 0;
  int doneBefore  = 0;
  int sbId        = 0;
  int expQ [$];

  tone_scheduler #(
    .NUM_REQ(4),
    .PERIOD_BITS(16),
    .DUR_BITS(12),
    .GAP_MS(1)
  ) dut (
    .inputClock(inputClock),
    .reset_n(reset_n),
    .msTick(msTick),
    .req(req),
    .halfPeriod(halfPeriod),
    .duration(duration),
    .stop(stop),
    .ack(ack),
    .busy(busy),
    .activeId(activeId),
    .toneOut(toneOut),
    .done(done)
  );

  always #5 inputClock = ~inputClock;

  always_comb begin
    halfPeriod = '0;
    duration   = '0;
    for (int i = 0; i < 4; i++) begin
      halfPeriod[i*16 +: 16] = hArr[i];
      duration[i*12 +: 12]   = dArr[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge inputClock);
    #1;
  endtask

  task automatic msPulse();
    msTick = 1'b1;
    tick();
    msTick = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] reqVal);
    req = reqVal;
  endtask

  task automatic setChan(input logic [1:0] ch, input logic [15:0] h, input logic [11:0] d);
    hArr[ch] = h;
    dArr[ch] = d;
  endtask

  task automatic waitAck(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack === 4'b0 && n < 50);
    if (ack === 4'b0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL %s: observed ack=%0h after 50 cycles, expected a grant", tag, ack);
    end
  endtask

  // Every grant pulse must match the next id the stimulus predicted.
  always @(negedge inputClock) begin
    if (reset_n === 1'b1 && ack !== 4'b0) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $error("[TB] FAIL sb_unexpected_ack: observed ack=%0h expected none", ack);
      end else begin
        sbId = expQ.pop_front();
        checkOutput("sb_ack", 32'(ack), 32'(1) << sbId);
        checkOutput("sb_activeId", 32'(activeId), 32'(sbId));
      end
    end
    if (done === 1'b1) doneCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    msTick  = 1'b0;
    req     = 4'b0;
    stop    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hArr[i] = '0;
      dArr[i] = '0;
    end

    tick();
    checkOutput("rst_ack", 32'(ack), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_activeId", 32'(activeId), 32'(0));
    checkOutput("rst_toneOut", 32'(toneOut), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    #2 reset_n = 1'b1;
    tick();

    // Round-robin from reset: 0,1,2,3 each with tone, done and gap
    for (int i = 0; i < 4; i++) begin
      setChan(2'(i), 16'd5, 12'd2);
      expQ.push_back(i);
    end
    applyStimulus(4'b1111);
    for (int i = 0; i < 4; i++) begin
      waitAck("arb_ack");
      checkOutput("arb_activeId", 32'(activeId), 32'(i));
      checkOutput("arb_busy", 32'(busy), 32'(1));
      if (i == 3) applyStimulus(4'b0000);
      msPulse();
      msPulse();
      checkOutput("arb_done", 32'(done), 32'(1));
      checkOutput("arb_gap_busy", 32'(busy), 32'(1));
      msPulse();
      checkOutput("arb_gap_idle", 32'(busy), 32'(0));
    end

    // Divider H=3: rises 3 cycles after ack, period 6
    setChan(2'd1, 16'd3, 12'd1);
    expQ.push_back(1);
    applyStimulus(4'b0010);
    waitAck("div_ack");
    applyStimulus(4'b0000);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("div_toneOut", 32'(toneOut), 32'((k / 3) % 2));
    end
    msPulse();
    checkOutput("div_done", 32'(done), 32'(1));
    checkOutput("div_tone_after_done", 32'(toneOut), 32'(0));
    msPulse();
    checkOutput("div_idle", 32'(busy), 32'(0));

    // Rest H=0 with D=3
    setChan(2'd2, 16'd0, 12'd3);
    expQ.push_back(2);
    applyStimulus(4'b0100);
    waitAck("rest_ack");
    applyStimulus(4'b0000);
    for (int m = 1; m <= 3; m++) begin
      repeat (4) tick();
      checkOutput("rest_toneOut", 32'(toneOut), 32'(0));
      msPulse();
      checkOutput("rest_done", 32'(done), 32'(m == 3));
      checkOutput("rest_toneOut_tick", 32'(toneOut), 32'(0));
    end
    msPulse();

    // Zero duration: done on the cycle after ack
    setChan(2'd0, 16'd5, 12'd0);
    expQ.push_back(0);
    applyStimulus(4'b0001);
    waitAck("d0_ack");
    applyStimulus(4'b0000);
    tick();
    checkOutput("d0_done", 32'(done), 32'(1));
    checkOutput("d0_toneOut", 32'(toneOut), 32'(0));
    msPulse();
    checkOutput("d0_idle", 32'(busy), 32'(0));

    // Fairness: req0 held, req2 raised during req0's tone
    setChan(2'd0, 16'd5, 12'd2);
    setChan(2'd2, 16'd5, 12'd2);
    expQ.push_back(0);
    expQ.push_back(2);
    expQ.push_back(0);
    applyStimulus(4'b0001);
    waitAck("fair_ack0");
    tick();
    applyStimulus(4'b0101);
    msPulse();
    msPulse();
    msPulse();
    waitAck("fair_ack2");
    checkOutput("fair_id2", 32'(activeId), 32'(2));
    applyStimulus(4'b0001);
    msPulse();
    msPulse();
    msPulse();
    waitAck("fair_ack0b");
    checkOutput("fair_id0", 32'(activeId), 32'(0));
    applyStimulus(4'b0000);
    msPulse();
    msPulse();
    msPulse();

    // stop mid-tone, pending req3 granted one cycle later
    setChan(2'd1, 16'd4, 12'd100);
    setChan(2'd3, 16'd5, 12'd1);
    expQ.push_back(1);
    expQ.push_back(3);
    doneBefore = doneCount;
    applyStimulus(4'b0010);
    waitAck("stop_ack");
    applyStimulus(4'b1000);
    repeat (5) tick();
    checkOutput("stop_tone_high", 32'(toneOut), 32'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_toneOut", 32'(toneOut), 32'(0));
    checkOutput("stop_busy", 32'(busy), 32'(0));
    checkOutput("stop_no_done", 32'(done), 32'(0));
    tick();
    checkOutput("stop_regrant_ack", 32'(ack), 32'(4'b1000));
    checkOutput("stop_regrant_busy", 32'(busy), 32'(1));
    checkOutput("stop_done_count", 32'(doneCount), 32'(doneBefore));
    applyStimulus(4'b0000);
    msPulse();
    checkOutput("stop_req3_done", 32'(done), 32'(1));
    msPulse();

    // Async reset while toneOut is high
    setChan(2'd2, 16'd2, 12'd100);
    setChan(2'd0, 16'd5, 12'd1);
    expQ.push_back(2);
    applyStimulus(4'b0100);
    waitAck("rst_mid_ack");
    applyStimulus(4'b0000);
    tick();
    tick();
    checkOutput("rst_mid_tone_high", 32'(toneOut), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_toneOut", 32'(toneOut), 32'(0));
    checkOutput("rst_mid_busy", 32'(busy), 32'(0));
    expQ.push_back(0);
    expQ.push_back(3);
    applyStimulus(4'b1001);
    #2 reset_n = 1'b1;
    waitAck("rst_after_ack0");
    checkOutput("rst_after_id0", 32'(activeId), 32'(0));
    applyStimulus(4'b1000);
    msPulse();
    msPulse();
    waitAck("rst_after_ack3");
    checkOutput("rst_after_id3", 32'(activeId), 32'(3));
    applyStimulus(4'b0000);
    msPulse();
    msPulse();

    checkOutput("total_done", 32'(doneCount), 32'(13));
    checkOutput("sb_empty", 32'(expQ.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
- Shares one programmable square-wave tone divider among NUM_REQ requesters, such as per-button note channels or a song sequencer.
- Arbitrates round-robin and latches the winner's half-period and duration. It plays the tone for that many millisecond ticks, then inserts a fixed silent gap before the next grant.
- Sits between note sources and the audio output pin. The 1 kHz msTick strobe comes from the existing clock-divider chain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PERIOD_BITS, 16, width of the half-period count, in inputClock edges.
- DUR_BITS, 12, width of the duration field, in ms.
- GAP_MS, 10, silent ms inserted after each tone; 0 means no gap.

Ports:
- inputClock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- msTick  in  1  single-cycle 1 kHz enable strobe.
- req  in  NUM_REQ  level request per requester.
- halfPeriod  in  NUM_REQ*PERIOD_BITS  requester i uses bits [i*PERIOD_BITS +: PERIOD_BITS].
- duration  in  NUM_REQ*DUR_BITS  requester i uses bits [i*DUR_BITS +: DUR_BITS], in ms.
- stop  in  1  abort the current tone or gap.
- ack  out  NUM_REQ  one-cycle grant pulse, one-hot.
- busy  out  1  high whenever state is not IDLE.
- activeId  out  clog2(NUM_REQ)  index of the last granted requester.
- toneOut  out  1  square-wave output.
- done  out  1  one-cycle pulse when a tone completes normally.

Behaviour:
- Clock and reset: one clock, inputClock. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - ack=0, busy=0, activeId=0, toneOut=0, done=0.
  - state=IDLE; all counters=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first.
  - Reset mid-tone silences toneOut immediately (asynchronously).
- FSM states: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - If any req bit is set, grant the first set bit searching from pointer+1 upward with wrap-around.
  - At the next edge:
    - state=PLAY;
    - ack[i]=1 for exactly one cycle;
    - activeId=i and pointer=i;
    - latch halfPeriod[i] and duration[i];
    - clear the divider and ms counters.
  - Latency from req high (sampled) to ack, busy and PLAY is 1 cycle.
- PLAY, divider:
  - The divider counter increments every cycle.
  - When counter == H-1 (H = latched half-period): toneOut toggles and the counter clears.
  - Result: the first rising edge of toneOut occurs H cycles after PLAY entry; the period is 2H cycles.
  - H=0 is a rest: toneOut is held 0.
  - H=1: toneOut toggles every cycle.
- PLAY, duration:
  - The ms counter increments on each msTick seen while in PLAY.
  - On the msTick that makes the count equal D (D = latched duration), at the next edge:
    - done=1 for one cycle;
    - toneOut=0;
    - state=GAP.
  - The resulting tone length is between D-1 and D ms.
  - D=0: done pulses on the cycle after ack, with no toggles.
- GAP:
  - toneOut=0.
  - Count GAP_MS msTicks, then go to IDLE.
  - GAP_MS=0: GAP lasts exactly one cycle.
  - busy stays high throughout GAP.
- Request handling:
  - Requests seen during PLAY or GAP are not latched; level reqs simply stay pending.
  - Deasserting req after ack does not affect the tone.
  - Changing halfPeriod or duration after ack has no effect.
- stop:
  - In PLAY or GAP: at the next edge, state=IDLE and toneOut=0, with no done pulse.
  - stop is ignored in IDLE.
  - stop takes precedence over msTick completion in the same cycle.
- Simultaneous events:
  - A msTick arriving on the ack edge is not counted.
  - A req arriving in the same cycle the FSM returns to IDLE is evaluated on the following cycle.

Test Plan:
- Arbitration after reset: req=4'b1111, all H=5, D=2, GAP_MS=1 → acks in order 0,1,2,3, each preceded by done and a gap; activeId follows 0,1,2,3.
- Divider: single req1 with H=3, D=1, msTick every 1000 cycles → toneOut period 6 cycles; first rise 3 cycles after ack; done pulses once; toneOut=0 after done.
- Rest and zero duration: H=0, D=3 → toneOut stays 0 and done follows the 3rd msTick. Separately, D=0 → done the cycle after ack.
- Fairness: req0 held high continuously and req2 pulsed high during req0's PLAY → the next grant after the gap goes to 2, then back to 0.
- stop during PLAY (H=4, mid-tone): next edge gives toneOut=0, busy=0, no done pulse; a pending req is granted 1 cycle later.
- Reset mid-PLAY with toneOut=1: toneOut=0 immediately. After release, req3 and req0 both asserted → ack[0] first.
